// File: rtl/spt_pkt_chk_if.sv
// ----------------------------------------------------------------------------
// spt_pkt_chk_if
//
// Purpose : groups the two byte streams (port A and port B) that feed the
//           packet checker.
//
// Signals :
//   rx_a_vld   - byte valid, port A
//   rx_a_data  - byte, port A
//   rx_b_vld   - byte valid, port B
//   rx_b_data  - byte, port B
//
// Modports:
//   master - stream source (drives all signals)
//   slave  - packet checker (samples all signals)
// ----------------------------------------------------------------------------
interface spt_pkt_chk_if;

    logic       rx_a_vld;
    logic [7:0] rx_a_data;
    logic       rx_b_vld;
    logic [7:0] rx_b_data;

    modport master (
        output rx_a_vld,
        output rx_a_data,
        output rx_b_vld,
        output rx_b_data
    );

    modport slave (
        input  rx_a_vld,
        input  rx_a_data,
        input  rx_b_vld,
        input  rx_b_data
    );

endinterface

// File: rtl/spt_pkt_chk.sv
// ----------------------------------------------------------------------------
// spt_pkt_chk
//
// Purpose : framing checker for a byte stream selected from one of two ports.
//           Packet format: HEAD[15:8] HEAD[7:0] L <L payload bytes>
//           TAIL[15:8] TAIL[7:0]. Each packet outcome is reported as a
//           one-cycle pulse in the cycle after the deciding byte.
//
// Ports   :
//   clk_50m             in   sole clock, rising edge
//   rst_core_n          in   asynchronous active-low reset
//   scan_en, test_mode  in   DFT pins
//   cpuif_mode          in   1 = checking enabled, 0 = held idle
//   cpuif_port_sel      in   0 = port A, 1 = port B
//   rx                  in   byte streams (spt_pkt_chk_if.slave)
//   spt_cpuif_head_err  out  pulse: second head byte wrong
//   spt_cpuif_tail_err  out  pulse: a tail byte wrong
//   spt_cpuif_short_pkt out  pulse: length below MIN_LEN
//   spt_cpuif_long_pkt  out  pulse: length above MAX_LEN
//   spt_cpuif_ok_pkt    out  pulse: packet complete and well formed
//   spt_busy            out  high while a packet is in progress
// ----------------------------------------------------------------------------
module spt_pkt_chk #(
    parameter logic [15:0] HEAD    = 16'hEB90,
    parameter logic [15:0] TAIL    = 16'h0D0A,
    parameter logic [7:0]  MIN_LEN = 8'd4,
    parameter logic [7:0]  MAX_LEN = 8'd64,
    parameter int unsigned GAP_MAX = 16
) (
    input  logic         clk_50m,
    input  logic         rst_core_n,
    input  logic         scan_en,
    input  logic         test_mode,
    input  logic         cpuif_mode,
    input  logic         cpuif_port_sel,
    spt_pkt_chk_if.slave rx,
    output logic         spt_cpuif_head_err,
    output logic         spt_cpuif_tail_err,
    output logic         spt_cpuif_short_pkt,
    output logic         spt_cpuif_long_pkt,
    output logic         spt_cpuif_ok_pkt,
    output logic         spt_busy
);

    // Gap counter only has to reach GAP_MAX - 1 before the abort fires.
    localparam int unsigned GAP_W = (GAP_MAX > 1) ? $clog2(GAP_MAX + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = (GAP_MAX > 0) ? GAP_W'(GAP_MAX - 1) : '0;

    typedef enum logic [2:0] {
        StIdle,
        StHead1,
        StLen,
        StPayload,
        StTail0,
        StTail1
    } state_t;

    // ------------------------------------------------------------------------
    // Reset: asserts asynchronously, releases on a clock edge through a
    // two-flop synchroniser. Test mode hands the raw pin to the flops so the
    // scan controller owns reset directly.
    // ------------------------------------------------------------------------
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge clk_50m or negedge rst_core_n) begin
        if (!rst_core_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = test_mode ? rst_core_n : r_rst_sync[1];

    // scan_en only steers the inserted scan chain.
    logic w_unused_dft;
    assign w_unused_dft = scan_en;

    // ------------------------------------------------------------------------
    // Port selection
    // ------------------------------------------------------------------------
    logic       w_vld;
    logic [7:0] w_data;
    logic       w_sel_chg;
    logic       w_abort;

    state_t           r_state;
    logic [7:0]       r_pay_cnt;
    logic [GAP_W-1:0] r_gap_cnt;
    logic             r_port_sel;

    assign w_vld  = cpuif_port_sel ? rx.rx_b_vld  : rx.rx_a_vld;
    assign w_data = cpuif_port_sel ? rx.rx_b_data : rx.rx_a_data;

    // r_port_sel shadows the select of the previous cycle.
    assign w_sel_chg = (cpuif_port_sel != r_port_sel);

    // Silent abort: checking disabled, or the source switched mid-packet.
    // The byte in the abort cycle is dropped.
    assign w_abort = !cpuif_mode || ((r_state != StIdle) && w_sel_chg);

    // ------------------------------------------------------------------------
    // Packet FSM with registered event pulses
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_50m or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state             <= StIdle;
            r_pay_cnt           <= '0;
            r_gap_cnt           <= '0;
            r_port_sel          <= 1'b0;
            spt_cpuif_head_err  <= 1'b0;
            spt_cpuif_tail_err  <= 1'b0;
            spt_cpuif_short_pkt <= 1'b0;
            spt_cpuif_long_pkt  <= 1'b0;
            spt_cpuif_ok_pkt    <= 1'b0;
        end else begin
            r_port_sel          <= cpuif_port_sel;
            spt_cpuif_head_err  <= 1'b0;
            spt_cpuif_tail_err  <= 1'b0;
            spt_cpuif_short_pkt <= 1'b0;
            spt_cpuif_long_pkt  <= 1'b0;
            spt_cpuif_ok_pkt    <= 1'b0;

            if (w_abort) begin
                r_state   <= StIdle;
                r_pay_cnt <= '0;
                r_gap_cnt <= '0;
            end else if (w_vld) begin
                r_gap_cnt <= '0;
                unique case (r_state)
                    StIdle: begin
                        // Anything other than the first head byte is noise.
                        if (w_data == HEAD[15:8]) begin
                            r_state <= StHead1;
                        end
                    end
                    StHead1: begin
                        // A wrong byte here is consumed, not re-tried as a head.
                        if (w_data == HEAD[7:0]) begin
                            r_state <= StLen;
                        end else begin
                            spt_cpuif_head_err <= 1'b1;
                            r_state            <= StIdle;
                        end
                    end
                    StLen: begin
                        if (w_data < MIN_LEN) begin
                            spt_cpuif_short_pkt <= 1'b1;
                            r_state             <= StIdle;
                        end else if (w_data > MAX_LEN) begin
                            spt_cpuif_long_pkt <= 1'b1;
                            r_state            <= StIdle;
                        end else begin
                            r_pay_cnt <= w_data;
                            // Zero-length payload only reachable with MIN_LEN = 0.
                            r_state   <= (w_data == 8'd0) ? StTail0 : StPayload;
                        end
                    end
                    StPayload: begin
                        r_pay_cnt <= r_pay_cnt - 8'd1;
                        if (r_pay_cnt == 8'd1) begin
                            r_state <= StTail0;
                        end
                    end
                    StTail0: begin
                        if (w_data == TAIL[15:8]) begin
                            r_state <= StTail1;
                        end else begin
                            spt_cpuif_tail_err <= 1'b1;
                            r_state            <= StIdle;
                        end
                    end
                    StTail1: begin
                        if (w_data == TAIL[7:0]) begin
                            spt_cpuif_ok_pkt <= 1'b1;
                        end else begin
                            spt_cpuif_tail_err <= 1'b1;
                        end
                        r_state <= StIdle;
                    end
                    default: begin
                        r_state <= StIdle;
                    end
                endcase
            end else if (r_state != StIdle) begin
                // Idle cycle inside a packet; the GAP_MAX-th in a row aborts.
                if (r_gap_cnt == GAP_LAST) begin
                    r_state   <= StIdle;
                    r_pay_cnt <= '0;
                    r_gap_cnt <= '0;
                end else begin
                    r_gap_cnt <= r_gap_cnt + 1'b1;
                end
            end
        end
    end

    assign spt_busy = (r_state != StIdle);

endmodule

// File: tb/tb_spt_pkt_chk.sv
// ----------------------------------------------------------------------------
// tb_spt_pkt_chk
//
// Directed and randomised byte streams for spt_pkt_chk. Expected pulses and
// busy level per byte come from a parser that walks the byte list using the
// packet framing rules.
// ----------------------------------------------------------------------------
module tb_spt_pkt_chk;

    typedef logic [7:0] byte_t;

    localparam byte_t H0 = 8'hEB;
    localparam byte_t H1 = 8'h90;
    localparam byte_t T0 = 8'h0D;
    localparam byte_t T1 = 8'h0A;
    localparam int    MIN_L = 4;
    localparam int    MAX_L = 64;
    localparam int    GAP   = 16;

    // Pulse vector order: {head_err, tail_err, short, long, ok}
    localparam logic [4:0] P_NONE  = 5'b00000;
    localparam logic [4:0] P_HEAD  = 5'b10000;
    localparam logic [4:0] P_TAIL  = 5'b01000;
    localparam logic [4:0] P_SHORT = 5'b00100;
    localparam logic [4:0] P_LONG  = 5'b00010;
    localparam logic [4:0] P_OK    = 5'b00001;

    logic clk_50m        = 1'b0;
    logic rst_core_n     = 1'b0;
    logic scan_en        = 1'b0;
    logic test_mode      = 1'b0;
    logic cpuif_mode     = 1'b0;
    logic cpuif_port_sel = 1'b0;
    logic head_err, tail_err, short_pkt, long_pkt, ok_pkt, busy;
    logic [4:0] obs_p;

    int total = 0;
    int bad   = 0;

    byte_t      stim[$];
    logic [4:0] exp_ev[$];
    logic       exp_bz[$];

    spt_pkt_chk_if rx_if ();

    spt_pkt_chk dut (
        .clk_50m             (clk_50m),
        .rst_core_n          (rst_core_n),
        .scan_en             (scan_en),
        .test_mode           (test_mode),
        .cpuif_mode          (cpuif_mode),
        .cpuif_port_sel      (cpuif_port_sel),
        .rx                  (rx_if),
        .spt_cpuif_head_err  (head_err),
        .spt_cpuif_tail_err  (tail_err),
        .spt_cpuif_short_pkt (short_pkt),
        .spt_cpuif_long_pkt  (long_pkt),
        .spt_cpuif_ok_pkt    (ok_pkt),
        .spt_busy            (busy)
    );

    assign obs_p = {head_err, tail_err, short_pkt, long_pkt, ok_pkt};

    always #10 clk_50m = ~clk_50m;

    // ---------------------------------------------------------------- checks
    task automatic check_now(input logic [4:0] ep, input logic eb, input string tag);
        total++;
        assert (obs_p === ep) else begin
            bad++;
            $error("FAIL %s: pulses observed=%b expected=%b", tag, obs_p, ep);
        end
        total++;
        assert (busy === eb) else begin
            bad++;
            $error("FAIL %s: busy observed=%b expected=%b", tag, busy, eb);
        end
    endtask

    task automatic tick(input logic [4:0] ep, input logic eb, input string tag);
        @(posedge clk_50m);
        #1;
        check_now(ep, eb, tag);
    endtask

    // Drive one port; the other port carries random noise.
    task automatic drive(input logic port, input logic vld, input byte_t d);
        logic  nv;
        byte_t nd;
        nv = ($urandom_range(0, 1) != 0);
        nd = byte_t'($urandom);
        if (port == 1'b0) begin
            rx_if.rx_a_vld = vld; rx_if.rx_a_data = d;
            rx_if.rx_b_vld = nv;  rx_if.rx_b_data = nd;
        end else begin
            rx_if.rx_b_vld = vld; rx_if.rx_b_data = d;
            rx_if.rx_a_vld = nv;  rx_if.rx_a_data = nd;
        end
    endtask

    // ---------------------------------------------------------------- model
    function automatic void mark_busy(input int lo, input int hi);
        for (int j = lo; j < hi; j++) exp_bz[j] = 1'b1;
    endfunction

    // Walk the selected-port byte list: for each byte, the pulse it causes
    // and whether a packet is still open after it.
    function automatic void model_parse(input byte_t s[$]);
        int n, i, t, len;
        n = s.size();
        exp_ev.delete();
        exp_bz.delete();
        for (int j = 0; j < n; j++) begin
            exp_ev.push_back(P_NONE);
            exp_bz.push_back(1'b0);
        end
        i = 0;
        while (i < n) begin
            if (s[i] != H0) begin
                i = i + 1;
            end else if (i + 1 >= n) begin
                mark_busy(i, n); i = n;
            end else if (s[i+1] != H1) begin
                mark_busy(i, i + 1); exp_ev[i+1] = P_HEAD; i = i + 2;
            end else if (i + 2 >= n) begin
                mark_busy(i, n); i = n;
            end else begin
                len = int'(s[i+2]);
                if (len < MIN_L) begin
                    mark_busy(i, i + 2); exp_ev[i+2] = P_SHORT; i = i + 3;
                end else if (len > MAX_L) begin
                    mark_busy(i, i + 2); exp_ev[i+2] = P_LONG; i = i + 3;
                end else begin
                    t = i + 3 + len;
                    if (t >= n) begin
                        mark_busy(i, n); i = n;
                    end else if (s[t] != T0) begin
                        mark_busy(i, t); exp_ev[t] = P_TAIL; i = t + 1;
                    end else if (t + 1 >= n) begin
                        mark_busy(i, n); i = n;
                    end else begin
                        mark_busy(i, t + 1);
                        exp_ev[t+1] = (s[t+1] == T1) ? P_OK : P_TAIL;
                        i = t + 2;
                    end
                end
            end
        end
    endfunction

    // Send a byte list on the selected port, random idle cycles up to maxg
    // before each byte (exactly glen before byte gidx), checking every cycle.
    task automatic drive_stream(input byte_t s[$], input int maxg, input int gidx,
                                input int glen, input logic port, input string tag);
        logic busy_now;
        int   g;
        model_parse(s);
        busy_now = 1'b0;
        foreach (s[k]) begin
            g = (k == gidx) ? glen : int'($urandom_range(0, maxg));
            repeat (g) begin
                drive(port, 1'b0, 8'h00);
                tick(P_NONE, busy_now, tag);
            end
            drive(port, 1'b1, s[k]);
            tick(exp_ev[k], exp_bz[k], tag);
            busy_now = exp_bz[k];
        end
        drive(port, 1'b0, 8'h00);
    endtask

    // ---------------------------------------------------------------- builders
    function automatic void push_hdr(input byte_t len);
        stim.push_back(H0);
        stim.push_back(H1);
        stim.push_back(len);
    endfunction

    function automatic void push_body(input int n, input byte_t t0, input byte_t t1,
                                      input logic with_t1);
        for (int j = 0; j < n; j++) stim.push_back(byte_t'($urandom));
        stim.push_back(t0);
        if (with_t1) stim.push_back(t1);
    endfunction

    // ---------------------------------------------------------------- sequence
    initial begin
        int    npk, kind, nfill, len;
        byte_t x;
        logic  port;

        rx_if.rx_a_vld = 1'b0; rx_if.rx_a_data = 8'h00;
        rx_if.rx_b_vld = 1'b0; rx_if.rx_b_data = 8'h00;

        // Reset: outputs quiet even with traffic on the selected port.
        #15;
        check_now(P_NONE, 1'b0, "reset");
        cpuif_mode = 1'b1;
        drive(1'b0, 1'b1, H0);
        tick(P_NONE, 1'b0, "reset_traffic");
        drive(1'b0, 1'b0, 8'h00);
        tick(P_NONE, 1'b0, "reset_idle");
        rst_core_n = 1'b1;
        repeat (3) tick(P_NONE, 1'b0, "reset_release");

        // Basic good packet.
        stim = {H0, H1, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, T0, T1};
        drive_stream(stim, 0, -1, 0, 1'b0, "basic_ok");
        tick(P_NONE, 1'b0, "basic_after");

        // Head error, short, long, maximum-length good packet.
        stim = {H0, 8'h91, H0, H1, 8'h03, H0, H1, 8'h41};
        push_hdr(8'h40);
        push_body(64, T0, T1, 1'b1);
        drive_stream(stim, 0, -1, 0, 1'b0, "len_bounds");

        // Minimum length accepted; bad tail in either position.
        stim.delete();
        push_hdr(8'h04); push_body(4, T0, T1, 1'b1);
        push_hdr(8'h04); push_body(4, T0, 8'h0B, 1'b1);
        push_hdr(8'h04); push_body(4, 8'h0E, 8'h00, 1'b0);
        drive_stream(stim, 0, -1, 0, 1'b0, "tail_err");

        // Port B selected: port A traffic is ignored, port B is checked.
        cpuif_port_sel = 1'b1;
        stim = {H0, H1, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, T0, T1};
        foreach (stim[k]) begin
            rx_if.rx_a_vld = 1'b1; rx_if.rx_a_data = stim[k];
            rx_if.rx_b_vld = 1'b0; rx_if.rx_b_data = 8'h00;
            tick(P_NONE, 1'b0, "unsel_port_a");
        end
        drive_stream(stim, 1, -1, 0, 1'b1, "port_b_ok");

        // Select change mid-payload: silent abort, busy drops next cycle.
        cpuif_port_sel = 1'b0;
        drive(1'b0, 1'b0, 8'h00);
        tick(P_NONE, 1'b0, "sel_back_idle");
        stim = {H0, H1, 8'h04, 8'h11, 8'h22};
        drive_stream(stim, 0, -1, 0, 1'b0, "sel_pre");
        cpuif_port_sel = 1'b1;
        rx_if.rx_a_vld = 1'b1; rx_if.rx_a_data = 8'h33;
        rx_if.rx_b_vld = 1'b1; rx_if.rx_b_data = H0;
        tick(P_NONE, 1'b0, "sel_toggle");
        stim = {8'h44, T0, T1};
        foreach (stim[k]) begin
            rx_if.rx_a_vld = 1'b1; rx_if.rx_a_data = stim[k];
            rx_if.rx_b_vld = 1'b0;
            tick(P_NONE, 1'b0, "sel_rest");
        end
        cpuif_port_sel = 1'b0;
        drive(1'b0, 1'b0, 8'h00);
        tick(P_NONE, 1'b0, "sel_restore");

        // Gap of GAP idle cycles aborts; rest of the packet is noise.
        stim = {H0, H1, 8'h04, 8'h11};
        drive_stream(stim, 0, -1, 0, 1'b0, "gap16_pre");
        for (int k = 1; k <= GAP; k++) begin
            drive(1'b0, 1'b0, 8'h00);
            tick(P_NONE, (k < GAP), "gap16_idle");
        end
        stim = {8'h22, 8'h33, 8'h44, T0, T1};
        drive_stream(stim, 0, -1, 0, 1'b0, "gap16_rest");

        // Gap of GAP-1 idle cycles is tolerated.
        stim = {H0, H1, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, T0, T1};
        drive_stream(stim, 0, 4, GAP - 1, 1'b0, "gap15_ok");

        // Checking disabled mid-packet, then a whole packet while disabled.
        stim = {H0, H1, 8'h04};
        drive_stream(stim, 0, -1, 0, 1'b0, "mode_pre");
        cpuif_mode = 1'b0;
        drive(1'b0, 1'b1, 8'h11);
        tick(P_NONE, 1'b0, "mode_off");
        stim = {H0, H1, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, T0, T1};
        foreach (stim[k]) begin
            drive(1'b0, 1'b1, stim[k]);
            tick(P_NONE, 1'b0, "mode_off_pkt");
        end
        cpuif_mode = 1'b1;
        drive(1'b0, 1'b0, 8'h00);
        tick(P_NONE, 1'b0, "mode_on");

        // Reset mid-payload, release, then a good packet.
        stim = {H0, H1, 8'h04, 8'h11, 8'h22};
        drive_stream(stim, 0, -1, 0, 1'b0, "rst_pre");
        rst_core_n = 1'b0;
        #1;
        check_now(P_NONE, 1'b0, "rst_async");
        drive(1'b0, 1'b1, 8'h33);
        tick(P_NONE, 1'b0, "rst_hold");
        drive(1'b0, 1'b0, 8'h00);
        tick(P_NONE, 1'b0, "rst_hold");
        rst_core_n = 1'b1;
        repeat (3) tick(P_NONE, 1'b0, "rst_release");
        stim = {H0, H1, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, T0, T1};
        drive_stream(stim, 0, -1, 0, 1'b0, "rst_post_ok");

        // Random streams of mixed packets on a random port.
        for (int it = 0; it < 25; it++) begin
            port           = ($urandom_range(0, 1) != 0);
            cpuif_port_sel = port;
            stim.delete();
            npk = int'($urandom_range(1, 4));
            for (int p = 0; p < npk; p++) begin
                nfill = int'($urandom_range(0, 2));
                for (int f = 0; f < nfill; f++) begin
                    x = byte_t'($urandom);
                    if (x == H0) x = 8'h00;
                    stim.push_back(x);
                end
                kind = int'($urandom_range(0, 5));
                case (kind)
                    0: begin
                        len = int'($urandom_range(MIN_L, MAX_L));
                        push_hdr(byte_t'(len)); push_body(len, T0, T1, 1'b1);
                    end
                    1: push_hdr(byte_t'($urandom_range(0, MIN_L - 1)));
                    2: push_hdr(byte_t'($urandom_range(MAX_L + 1, 255)));
                    3: begin
                        x = byte_t'($urandom);
                        if (x == H1) x = 8'h91;
                        stim.push_back(H0); stim.push_back(x);
                    end
                    4: begin
                        len = int'($urandom_range(MIN_L, MAX_L));
                        x = byte_t'($urandom);
                        if (x == T0) x = 8'h0E;
                        push_hdr(byte_t'(len)); push_body(len, x, 8'h00, 1'b0);
                    end
                    default: begin
                        len = int'($urandom_range(MIN_L, MAX_L));
                        x = byte_t'($urandom);
                        if (x == T1) x = 8'h0B;
                        push_hdr(byte_t'(len)); push_body(len, T0, x, 1'b1);
                    end
                endcase
            end
            drive_stream(stim, 2, -1, 0, port, "random");
        end
        tick(P_NONE, 1'b0, "final_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spt_pkt_chk.md
SPT_PKT_CHK -- requirements
Module: spt_pkt_chk

Parameters
REQ-001 SHALL have parameter HEAD, default 16'hEB90; header bytes, sent MSB byte first.
REQ-002 SHALL have parameter TAIL, default 16'h0D0A; tail bytes, sent MSB byte first.
REQ-003 SHALL have parameter MIN_LEN, default 8'd4; minimum legal payload length (inclusive).
REQ-004 SHALL have parameter MAX_LEN, default 8'd64; maximum legal payload length (inclusive).
REQ-005 SHALL have parameter GAP_MAX, default 16; maximum idle cycles allowed between bytes inside a packet.

Interface
REQ-006 clk_50m  in  1  sole clock, rising edge.
REQ-007 rst_core_n  in  1  asynchronous active-low reset.
REQ-008 scan_en, test_mode  in  1 each  DFT pins; no functional effect.
REQ-009 cpuif_mode  in  1  1 = checking enabled; 0 = FSM held in IDLE, inputs ignored.
REQ-010 cpuif_port_sel  in  1  0 = port A stream, 1 = port B stream.
REQ-011 rx_a_vld / rx_b_vld  in  1  byte valid per port.
REQ-012 rx_a_data / rx_b_data  in  8  byte per port.
REQ-013 spt_cpuif_head_err, spt_cpuif_tail_err, spt_cpuif_short_pkt, spt_cpuif_long_pkt, spt_cpuif_ok_pkt  out  1 each  one-cycle event pulses, registered.
REQ-014 spt_busy  out  1  high while FSM is not in IDLE.

Function
REQ-015 SHALL check the selected port's vld/data with a mux; bytes count only on cycles where the selected vld is 1.
REQ-016 SHALL use packet format: HEAD[15:8], HEAD[7:0], length byte L, L payload bytes, TAIL[15:8], TAIL[7:0].
REQ-017 SHALL use FSM states IDLE, HEAD1, LEN, PAYLOAD, TAIL0, TAIL1.
REQ-018 IDLE: byte == HEAD[15:8] -> HEAD1; any other byte is discarded with no pulse.
REQ-019 HEAD1: byte == HEAD[7:0] -> LEN; otherwise pulse head_err and go to IDLE, without re-evaluating that byte.
REQ-020 LEN, L < MIN_LEN: pulse short_pkt, go to IDLE.
REQ-021 LEN, L > MAX_LEN: pulse long_pkt, go to IDLE.
REQ-022 LEN, MIN_LEN <= L <= MAX_LEN: load the 8-bit payload counter with L, go to PAYLOAD.
REQ-023 PAYLOAD: decrement the counter per byte; the byte taking the counter to 0 -> TAIL0; payload content is not checked.
REQ-024 TAIL0: byte == TAIL[15:8] -> TAIL1; otherwise pulse tail_err and go to IDLE.
REQ-025 TAIL1: byte == TAIL[7:0] -> pulse ok_pkt; otherwise pulse tail_err; go to IDLE in both cases.
REQ-026 Pulse latency: the deciding byte is presented in cycle N; the pulse is high in cycle N+1 only.
REQ-027 At most one of the five pulses SHALL be high in any cycle.
REQ-028 Back-to-back packets with no idle gap SHALL be accepted; the first head byte may arrive in the cycle after the deciding byte.
REQ-029 Gap counter: in any non-IDLE state, count consecutive cycles with vld = 0; reset the count on vld = 1.
REQ-030 When the gap count reaches GAP_MAX, the FSM SHALL abort to IDLE with no pulse.
REQ-031 A change of cpuif_port_sel while not in IDLE SHALL abort to IDLE with no pulse; the byte in that cycle is ignored.
REQ-032 cpuif_mode falling to 0 while not in IDLE SHALL abort to IDLE with no pulse; an already-registered pulse still completes.
REQ-033 The non-selected port's vld/data SHALL have no effect.

Reset
REQ-034 While rst_core_n = 0: FSM = IDLE, payload counter = 0, gap counter = 0, port_sel shadow register = 0.
REQ-035 While rst_core_n = 0: all five pulses = 0 and spt_busy = 0.
REQ-036 Reset is asynchronous assert and synchronous release; reset asserted mid-packet discards the packet and emits no pulse.

Verification
REQ-037 mode=1, sel=0, port A sends EB 90 04 11 22 33 44 0D 0A contiguously -> ok_pkt high exactly one cycle, the cycle after 0A; no other pulses; spt_busy low afterwards.
REQ-038 Port A sends EB 91 -> head_err one cycle after 91. Then EB 90 03 -> short_pkt. Then EB 90 41 -> long_pkt. Then EB 90 40 + 64 bytes + 0D 0A -> ok_pkt.
REQ-039 EB 90 04 + 4 bytes + 0D 0B -> tail_err after 0B. Next, EB 90 04 + 4 bytes + 0E -> tail_err after 0E.
REQ-040 sel=1, port A sends a valid packet while port B is idle -> no pulse. Then port B sends a valid packet -> ok_pkt. Then sel toggles mid-payload -> no pulse, spt_busy drops next cycle.
REQ-041 EB 90 04 11, then vld low 16 cycles, then the rest of the packet -> abort with no ok_pkt. With a 15-cycle gap instead -> ok_pkt.
REQ-042 Reset asserted mid-payload, then released, then a valid packet -> outputs 0 during reset, then exactly one ok_pkt.
